axi_lite_deco_n: RTL
====================

// Module: axi_lite_deco_n
// PURPOSE
//  Parametrised AXI-Lite address decoder: one PS-side AXI-Lite slave fanned out to OUTS register-bank masters.
//  Successor to the fixed 4-way decoder. Bank select is latched per transaction and held to completion.
//  Unmapped banks get a DECERR response. Reads and writes are strictly serialised, one outstanding.
//  Sits between the PS AXI-Lite port and the processor/peripheral register banks inside axis_qick_processor.
// PARAMETERS
//  OUTS        4     number of master ports, 1..16
//  ADDR_W      8     AXI-Lite address width
//  DATA_W      32    data width; strobe width is DATA_W/8
//  BANK_LSB    6     lowest address bit of bank field
//  BANK_W      2     bank field width; 2**BANK_W >= OUTS
//  TIMEOUT_CYC 1024  response timeout in cycles; used only with the macro
// PORTS
//  ps_aclk      in   1                 clock
//  ps_aresetn   in   1                 async active-low reset
//  s_axi_lite   slv  TYPE_AXI_LITE_IF_IN  PS-side AXI-Lite slave
//  m_awaddr     out  OUTS*ADDR_W       per-master AW address; also m_awprot[OUTS*3], m_awvalid[OUTS]
//  m_awready    in   OUTS              per-master AW ready
//  m_wdata      out  OUTS*DATA_W       per-master W data; also m_wstrb[OUTS*DATA_W/8], m_wvalid[OUTS]
//  m_wready     in   OUTS              per-master W ready
//  m_bresp      in   OUTS*2            per-master B response; also m_bvalid[OUTS] in, m_bready[OUTS] out
//  m_araddr     out  OUTS*ADDR_W       per-master AR address; also m_arprot[OUTS*3], m_arvalid[OUTS]
//  m_arready    in   OUTS              per-master AR ready
//  m_rdata      in   OUTS*DATA_W       per-master R data; also m_rresp[OUTS*2], m_rvalid[OUTS] in, m_rready[OUTS] out
//  err_cnt      out  16                count of DECERR/SLVERR responses; saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset: FSM=IDLE, sel=0. All m_*valid/m_*ready=0. All s_* ready/valid=0. err_cnt=0.
//    Reset is asserted asynchronously and released synchronously to ps_aclk.
//  - FSM states: IDLE, RD, WR, ERR_RD, ERR_WR.
//  - IDLE:
//    - arvalid -> latch sel=araddr[BANK_LSB+:BANK_W]; go to RD, or ERR_RD if sel>=OUTS.
//    - else awvalid -> latch sel from awaddr; go to WR, or ERR_WR if sel>=OUTS.
//    - arvalid and awvalid together: the read wins; the write waits.
//    - IDLE asserts no ready toward s_axi_lite. Decode costs exactly 1 cycle of added latency.
//  - RD: AR and R of master[sel] are wired combinationally to s_axi_lite. Non-selected masters see zeros.
//    - After AR handshake, arvalid to master[sel] is gated to 0.
//    - Exit to IDLE on rvalid&rready.
//  - WR: AW, W and B of master[sel] are forwarded. AW and W may complete in either order; each is gated after its handshake.
//    - Exit to IDLE on bvalid&bready.
//  - ERR_RD: the decoder itself accepts AR (arready pulse 1 cycle), then drives rvalid=1, rresp=2'b11, rdata=0 until rready.
//  - ERR_WR: the decoder accepts AW and W, then drives bvalid=1, bresp=2'b11 until bready.
//  - err_cnt increments on each completed error response.
//  - A new transaction is accepted only in IDLE. Changes on s_* addr mid-transaction do not move sel.
//  - Reset mid-transaction: all valids drop immediately. A master response arriving later is ignored.
// CONFIGURATION
//  - AXI_DECO_TIMEOUT_EN defined:
//    - In RD/WR a 16-bit counter runs from the first state cycle. It clears only on state exit.
//    - When the counter reaches TIMEOUT_CYC, master valids/readys are forced to 0 and the FSM goes to ERR_RD/ERR_WR.
//    - The error state then returns SLVERR 2'b10 instead of DECERR, and err_cnt increments.
//    - If AR/AW was not yet accepted by the master, the decoder accepts it itself.
//  - Not defined: no counter. The FSM waits on the selected master indefinitely. TIMEOUT_CYC is unused.
// STRUCTURE
//  - Package qick_axi_pkg holds:
//    - RESP_OKAY/SLVERR/DECERR localparams (2'b00/2'b10/2'b11).
//    - typedef enum logic[2:0] deco_state_t.
//  - Sub-module axi_lite_err_slave: the ERR_RD/ERR_WR responder. Input resp code, with a handshake to the parent FSM.
//  - Per-master mux/demux is built with a generate-for over OUTS.
// TESTING
//  1. OUTS=4. Write 0x44 data 0xDEADBEEF -> only m_awvalid[1] high. B OKAY returned. Other masters see all-zero inputs.
//  2. OUTS=3. Read 0xC0 -> no master sees arvalid. rresp=2'b11, rdata=0. err_cnt 0->1.
//  3. arvalid(0x00) and awvalid(0x80) in the same cycle -> read to master0 completes first, then the write to master2.
//  4. Master1 delays rvalid 20 cycles, s_rready low 5 more -> rvalid held; FSM stays RD; next AR not accepted until R handshake.
//  5. Macro on, TIMEOUT_CYC=16, master0 never asserts bvalid -> bresp=2'b10 at cycle 16+small constant; err_cnt=1; later m_bvalid[0] ignored.
//  6. Assert ps_aresetn low in RD mid-burst -> all valids 0 within the same cycle. Next read after reset completes with OKAY.

Source files
------------

// File: rtl/qick_axi_pkg.sv
// Shared AXI-Lite response codes and decoder state encoding for the qick AXI-Lite fabric.
package qick_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_ERR_RD,
        ST_ERR_WR
    } deco_state_t;

endpackage

// File: rtl/axi_lite_err_slave.sv
// Local responder used when a transaction cannot reach a master: accepts AR or AW/W itself and
// returns the response code supplied by the parent FSM.
module axi_lite_err_slave
    import qick_axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_req,
    input  logic       wr_req,
    input  logic [1:0] resp,
    input  logic       ar_done,
    input  logic       aw_done,
    input  logic       w_done,
    input  logic       arvalid,
    input  logic       awvalid,
    input  logic       wvalid,
    input  logic       rready,
    input  logic       bready,
    output logic       arready,
    output logic       awready,
    output logic       wready,
    output logic       rvalid,
    output logic [1:0] rresp,
    output logic       bvalid,
    output logic [1:0] bresp,
    output logic       done
);

    logic [1:0] resp_q;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            rvalid  <= 1'b0;
            bvalid  <= 1'b0;
            resp_q  <= RESP_OKAY;
        end else begin
            // Ready pulses for one cycle; the parent's done flags stop a second acceptance.
            arready <= rd_req && !ar_done && arvalid && !arready;
            awready <= wr_req && !aw_done && awvalid && !awready;
            wready  <= wr_req && !w_done && wvalid && !wready;
            if (rvalid) begin
                if (rready) rvalid <= 1'b0;
            end else if (rd_req && ar_done) begin
                rvalid <= 1'b1;
                resp_q <= resp;
            end
            if (bvalid) begin
                if (bready) bvalid <= 1'b0;
            end else if (wr_req && aw_done && w_done) begin
                bvalid <= 1'b1;
                resp_q <= resp;
            end
        end
    end

    assign rresp = rvalid ? resp_q : RESP_OKAY;
    assign bresp = bvalid ? resp_q : RESP_OKAY;
    assign done  = (rvalid && rready) || (bvalid && bready);

endmodule

// File: rtl/axi_lite_deco_n.sv
// AXI-Lite 1-to-OUTS address decoder, one outstanding transaction, bank latched per transaction.
// Optional response timeout enabled by defining AXI_DECO_TIMEOUT_EN.
module axi_lite_deco_n
    import qick_axi_pkg::*;
#(
    parameter int OUTS        = 4,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int BANK_LSB    = 6,
    parameter int BANK_W      = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     ps_aclk,
    input  logic                     ps_aresetn,
    input  logic [ADDR_W-1:0]        s_awaddr,
    input  logic [2:0]               s_awprot,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [DATA_W-1:0]        s_wdata,
    input  logic [DATA_W/8-1:0]      s_wstrb,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [1:0]               s_bresp,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    input  logic [ADDR_W-1:0]        s_araddr,
    input  logic [2:0]               s_arprot,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [DATA_W-1:0]        s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [OUTS*ADDR_W-1:0]   m_awaddr,
    output logic [OUTS*3-1:0]        m_awprot,
    output logic [OUTS-1:0]          m_awvalid,
    input  logic [OUTS-1:0]          m_awready,
    output logic [OUTS*DATA_W-1:0]   m_wdata,
    output logic [OUTS*DATA_W/8-1:0] m_wstrb,
    output logic [OUTS-1:0]          m_wvalid,
    input  logic [OUTS-1:0]          m_wready,
    input  logic [OUTS*2-1:0]        m_bresp,
    input  logic [OUTS-1:0]          m_bvalid,
    output logic [OUTS-1:0]          m_bready,
    output logic [OUTS*ADDR_W-1:0]   m_araddr,
    output logic [OUTS*3-1:0]        m_arprot,
    output logic [OUTS-1:0]          m_arvalid,
    input  logic [OUTS-1:0]          m_arready,
    input  logic [OUTS*DATA_W-1:0]   m_rdata,
    input  logic [OUTS*2-1:0]        m_rresp,
    input  logic [OUTS-1:0]          m_rvalid,
    output logic [OUTS-1:0]          m_rready,
    output logic [15:0]              err_cnt
);

    localparam int STRB_W = DATA_W / 8;

    if (OUTS < 1 || OUTS > 16 || (1 << BANK_W) < OUTS || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
    begin : g_bad_params
        $error("axi_lite_deco_n: illegal parameter combination");
    end

    deco_state_t       state;
    logic [BANK_W-1:0] sel;
    logic [1:0]        err_code;
    logic              ar_done, aw_done, w_done;
    logic              to_hit;
    logic [OUTS-1:0]   rd_fwd, wr_fwd;

    logic [BANK_W-1:0] ar_bank, aw_bank;
    logic              ar_ok, aw_ok;
    assign ar_bank = s_araddr[BANK_LSB +: BANK_W];
    assign aw_bank = s_awaddr[BANK_LSB +: BANK_W];
    assign ar_ok   = 32'(ar_bank) < OUTS;
    assign aw_ok   = 32'(aw_bank) < OUTS;

    logic       es_arready, es_awready, es_wready, es_rvalid, es_bvalid, es_done;
    logic [1:0] es_rresp, es_bresp;

`ifdef AXI_DECO_TIMEOUT_EN
    logic [15:0] to_cnt;
    assign to_hit = (state == ST_RD || state == ST_WR) && (to_cnt == 16'(TIMEOUT_CYC));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge ps_aclk or negedge ps_aresetn) begin
        if (!ps_aresetn) begin
            state    <= ST_IDLE;
            sel      <= '0;
            err_code <= RESP_DECERR;
            ar_done  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            err_cnt  <= '0;
`ifdef AXI_DECO_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            if (s_arvalid && s_arready) ar_done <= 1'b1;
            if (s_awvalid && s_awready) aw_done <= 1'b1;
            if (s_wvalid && s_wready)   w_done  <= 1'b1;
`ifdef AXI_DECO_TIMEOUT_EN
            to_cnt <= (state == ST_RD || state == ST_WR) ? to_cnt + 16'd1 : '0;
`endif
            unique case (state)
                ST_IDLE: begin
                    ar_done  <= 1'b0;
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                    err_code <= RESP_DECERR;
                    // Reads take priority; a pending write is picked up on a later IDLE cycle.
                    if (s_arvalid) begin
                        sel   <= ar_bank;
                        state <= ar_ok ? ST_RD : ST_ERR_RD;
                    end else if (s_awvalid) begin
                        sel   <= aw_bank;
                        state <= aw_ok ? ST_WR : ST_ERR_WR;
                    end
                end
                ST_RD: begin
                    if (to_hit) begin
                        state    <= ST_ERR_RD;
                        err_code <= RESP_SLVERR;
                    end else if (s_rvalid && s_rready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (to_hit) begin
                        state    <= ST_ERR_WR;
                        err_code <= RESP_SLVERR;
                    end else if (s_bvalid && s_bready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ERR_RD, ST_ERR_WR: begin
                    if (es_done) begin
                        state <= ST_IDLE;
                        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axi_lite_err_slave u_err_slave (
        .clk     (ps_aclk),
        .rst_n   (ps_aresetn),
        .rd_req  (state == ST_ERR_RD),
        .wr_req  (state == ST_ERR_WR),
        .resp    (err_code),
        .ar_done (ar_done),
        .aw_done (aw_done),
        .w_done  (w_done),
        .arvalid (s_arvalid),
        .awvalid (s_awvalid),
        .wvalid  (s_wvalid),
        .rready  (s_rready),
        .bready  (s_bready),
        .arready (es_arready),
        .awready (es_awready),
        .wready  (es_wready),
        .rvalid  (es_rvalid),
        .rresp   (es_rresp),
        .bvalid  (es_bvalid),
        .bresp   (es_bresp),
        .done    (es_done)
    );

    for (genvar i = 0; i < OUTS; i++) begin : g_master
        assign rd_fwd[i] = !to_hit && state == ST_RD && sel == BANK_W'(i);
        assign wr_fwd[i] = !to_hit && state == ST_WR && sel == BANK_W'(i);

        assign m_araddr[i*ADDR_W +: ADDR_W] = rd_fwd[i] ? s_araddr : '0;
        assign m_arprot[i*3 +: 3]           = rd_fwd[i] ? s_arprot : '0;
        assign m_arvalid[i]                 = rd_fwd[i] && s_arvalid && !ar_done;
        assign m_rready[i]                  = rd_fwd[i] && s_rready;

        assign m_awaddr[i*ADDR_W +: ADDR_W] = wr_fwd[i] ? s_awaddr : '0;
        assign m_awprot[i*3 +: 3]           = wr_fwd[i] ? s_awprot : '0;
        assign m_awvalid[i]                 = wr_fwd[i] && s_awvalid && !aw_done;
        assign m_wdata[i*DATA_W +: DATA_W]  = wr_fwd[i] ? s_wdata : '0;
        assign m_wstrb[i*STRB_W +: STRB_W]  = wr_fwd[i] ? s_wstrb : '0;
        assign m_wvalid[i]                  = wr_fwd[i] && s_wvalid && !w_done;
        assign m_bready[i]                  = wr_fwd[i] && s_bready;
    end

    // NOTE: every output gets a default before the loop, so no path leaves a latch behind.
    always_comb begin
        s_arready = es_arready;
        s_rvalid  = es_rvalid;
        s_rresp   = es_rresp;
        s_rdata   = '0;
        s_awready = es_awready;
        s_wready  = es_wready;
        s_bvalid  = es_bvalid;
        s_bresp   = es_bresp;
        for (int i = 0; i < OUTS; i++) begin
            if (rd_fwd[i]) begin
                s_arready = m_arready[i] && !ar_done;
                s_rvalid  = m_rvalid[i];
                s_rresp   = m_rresp[i*2 +: 2];
                s_rdata   = m_rdata[i*DATA_W +: DATA_W];
            end
            if (wr_fwd[i]) begin
                s_awready = m_awready[i] && !aw_done;
                s_wready  = m_wready[i] && !w_done;
                s_bvalid  = m_bvalid[i];
                s_bresp   = m_bresp[i*2 +: 2];
            end
        end
    end

endmodule
